// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

    localparam int SERIAL_ADD_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_add_state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder shared by every bit position of a serial add.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic cy_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign cy_o = (a_i & b_i) | ((a_i ^ b_i) & c_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one fa_cell over WIDTH-bit operands, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
  , output logic             ovf_o
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    serial_add_state_e state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0]  res_q, res_d, res_shift;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              fa_s, fa_cy, accept;

    fa_cell u_fa (
        .a_i  (op_a_q[0]),
        .b_i  (op_b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .cy_o (fa_cy)
    );

    // Result register with the new sum bit entering at the MSB side.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = fa_s;
    end

    // FSM and datapath next-state; carry_q holds the carry into the MSB on the last bit.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                res_d   = res_shift;
                carry_d = fa_cy;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = res_shift;
                    cout_d  = fa_cy;
                    ovf_d   = carry_q ^ fa_cy;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (accept) begin
            state_d = SHIFT;
            op_a_d  = a_i;
            op_b_d  = b_i;
            carry_d = cin_i;
            res_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf_o  = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed scoreboard bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    exp_t       sb_q[$];
    exp_t       cur;
    logic [7:0] last_sum;
    logic       last_cout;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start8),
        .a_i     (a8),
        .b_i     (b8),
        .cin_i   (cin8),
        .busy_o  (busy8),
        .done_o  (done8),
        .sum_o   (sum8),
        .cout_o  (cout8)
`ifdef SERIAL_ADD_OVF_EN
      , .ovf_o   (ovf8)
`endif
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start1),
        .a_i     (a1),
        .b_i     (b1),
        .cin_i   (cin1),
        .busy_o  (busy1),
        .done_o  (done1),
        .sum_o   (sum1),
        .cout_o  (cout1)
`ifdef SERIAL_ADD_OVF_EN
      , .ovf_o   ()
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        exp_t       e;
        logic [8:0] full;
        logic [7:0] low;
        full   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        low    = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, cin};
        e.sum  = full[7:0];
        e.cout = full[8];
        e.ovf  = low[7] ^ full[8];
        return e;
    endfunction

    task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        sb_q.push_back(model8(a, b, cin));
    endtask

    // Called in a cycle where done must be high: pop and compare the result.
    task automatic check_done8();
        chk("done_pulse", {31'd0, done8}, 32'd1);
        chk("busy_in_done", {31'd0, busy8}, 32'd0);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            cur = sb_q.pop_front();
            chk("sum", {24'd0, sum8}, {24'd0, cur.sum});
            chk("cout", {31'd0, cout8}, {31'd0, cur.cout});
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf", {31'd0, ovf8}, {31'd0, cur.ovf});
`endif
            last_sum  = cur.sum;
            last_cout = cur.cout;
        end
    endtask

    // Checks cycles 1..8 of an add: busy high, no done, outputs held.
    task automatic shift_cycles8();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            chk("busy_shift", {31'd0, busy8}, 32'd1);
            chk("done_early", {31'd0, done8}, 32'd0);
            chk("sum_hold", {24'd0, sum8}, {24'd0, last_sum});
            chk("cout_hold", {31'd0, cout8}, {31'd0, last_cout});
        end
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        push8(a, b, cin);
        shift_cycles8();
        @(negedge clk);
        check_done8();
        @(negedge clk);
        chk("done_single", {31'd0, done8}, 32'd0);
        chk("busy_idle", {31'd0, busy8}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        last_sum = 8'd0; last_cout = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_sum", {24'd0, sum8}, 32'd0);
        chk("rst_cout", {31'd0, cout8}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", {31'd0, ovf8}, 32'd0);
`endif
        rst_n = 1'b1;

        add8(8'h5A, 8'h33, 1'b0);
        add8(8'hFF, 8'h01, 1'b0);
        add8(8'h00, 8'h00, 1'b1);
        add8(8'h7F, 8'h01, 1'b0);
        add8(8'h80, 8'h80, 1'b0);
        add8(8'hFF, 8'h01, 1'b0);
        for (int k = 0; k < 4; k++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Start held high: ignored during SHIFT, re-accepted on each done.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        push8(8'h10, 8'h20, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                chk("b2b_busy", {31'd0, busy8}, 32'd1);
                chk("b2b_done_early", {31'd0, done8}, 32'd0);
            end
            @(negedge clk);
            check_done8();
            if (r < 2) begin
                push8(8'h10, 8'h20, 1'b0);
            end else begin
                start8 = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle_done", {31'd0, done8}, 32'd0);
        chk("b2b_idle_busy", {31'd0, busy8}, 32'd0);

        // Reset in cycle 4 of an add: aborted, no done.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_sum", {24'd0, sum8}, 32'd0);
        chk("abort_cout", {31'd0, cout8}, 32'd0);
        rst_n = 1'b1;
        last_sum = 8'd0; last_cout = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done8}, 32'd0);
        end
        add8(8'hC3, 8'h4E, 1'b1);

        // WIDTH=1: exactly one SHIFT cycle.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", {31'd0, busy1}, 32'd1);
        chk("w1_done_early", {31'd0, done1}, 32'd0);
        @(negedge clk);
        chk("w1_done", {31'd0, done1}, 32'd1);
        chk("w1_sum", {31'd0, sum1}, 32'd1);
        chk("w1_cout", {31'd0, cout1}, 32'd1);
        @(negedge clk);
        chk("w1_done_single", {31'd0, done1}, 32'd0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
